// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for the unified memory port: m0 (MIPS core) and m1 (loader/DMA).
// Grants one access per cycle, supports locked m1 bursts and routes read data back by tag.
module mem_port_arbiter #(
  parameter int READ_LATENCY  = 1,
  parameter int PRIORITY_MODE = 0,
  parameter int STARVE_LIMIT  = 8,
  parameter int MAX_BURST     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic        m1_lock,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic [1:0]  owner,
  output logic        mem_we,
  output logic [31:0] mem_data_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  output logic [1:0]  dbg_state
);
  localparam int WAIT_W  = $clog2(STARVE_LIMIT + 1);
  localparam int BURST_W = $clog2(MAX_BURST + 1);
  localparam logic [WAIT_W-1:0]  WAIT_MAX  = WAIT_W'(STARVE_LIMIT);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);
  localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LOCKED = 2'd1, ST_RELEASE = 2'd2} state_t;

  state_t             r_state;
  logic [WAIT_W-1:0]  r_wait;
  logic [BURST_W-1:0] r_burst;
  logic               r_last_m1;
  logic [1:0]         r_pipe [READ_LATENCY];
  logic [31:0]        r_rdata0;
  logic [31:0]        r_rdata1;

  logic               w_gnt0;
  logic               w_gnt1;
  logic [BURST_W-1:0] w_burst_inc;
  logic [1:0]         w_chain [READ_LATENCY];

  // Handshake: a master raises req and holds req/we/addr/wdata stable until it
  // sees gnt high in the same cycle; that cycle is the whole access. Read data
  // returns later as a one-cycle rvalid pulse with rdata, which then holds.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (rst) begin
      case (r_state)
        ST_LOCKED:  w_gnt1 = m1_req;
        ST_RELEASE: begin
          w_gnt0 = m0_req;
          w_gnt1 = m1_req && !m0_req;
        end
        default: begin
          if (m0_req && m1_req) begin
            if (PRIORITY_MODE == 0) begin
              w_gnt1 = (r_wait == WAIT_MAX);
              w_gnt0 = (r_wait != WAIT_MAX);
            end else begin
              w_gnt0 = r_last_m1;
              w_gnt1 = !r_last_m1;
            end
          end else begin
            w_gnt0 = m0_req;
            w_gnt1 = m1_req;
          end
        end
      endcase
    end
  end

  always_comb begin
    mem_we         = 1'b0;
    mem_data_addr  = '0;
    mem_write_data = '0;
    if (w_gnt0) begin
      mem_we         = m0_we;
      mem_data_addr  = m0_addr;
      mem_write_data = m0_wdata;
    end else if (w_gnt1) begin
      mem_we         = m1_we;
      mem_data_addr  = m1_addr;
      mem_write_data = m1_wdata;
    end
  end

  assign m0_gnt    = w_gnt0;
  assign m1_gnt    = w_gnt1;
  assign owner     = {w_gnt1, w_gnt0};
  assign dbg_state = r_state;

  assign w_burst_inc = (r_burst == BURST_MAX) ? r_burst : r_burst + BURST_ONE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_burst   <= '0;
      r_wait    <= '0;
      r_last_m1 <= 1'b1;
    end else begin
      if (!m1_req || w_gnt1) r_wait <= '0;
      else if (r_wait != WAIT_MAX) r_wait <= r_wait + WAIT_W'(1);
      if (w_gnt0 || w_gnt1) r_last_m1 <= w_gnt1;
      case (r_state)
        ST_IDLE: begin
          if (w_gnt1 && m1_lock) begin
            r_burst <= BURST_ONE;
            r_state <= (BURST_MAX == BURST_ONE) ? ST_RELEASE : ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (w_gnt1) r_burst <= w_burst_inc;
          if (!m1_lock) r_state <= ST_IDLE;
          else if (w_gnt1 && w_burst_inc == BURST_MAX) r_state <= ST_RELEASE;
        end
        ST_RELEASE: begin
          r_burst <= '0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Tag chain: element i is what lands in r_pipe[i]; the last stage is the rvalid pair,
  // so mem_read_data is captured on the edge that completes READ_LATENCY.
  always_comb begin
    w_chain[0] = (w_gnt0 && !m0_we) ? 2'b01 :
                 (w_gnt1 && !m1_we) ? 2'b10 : 2'b00;
    for (int i = 1; i < READ_LATENCY; i++) w_chain[i] = r_pipe[i-1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < READ_LATENCY; i++) r_pipe[i] <= 2'b00;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      for (int i = 0; i < READ_LATENCY; i++) r_pipe[i] <= w_chain[i];
      if (w_chain[READ_LATENCY-1][0]) r_rdata0 <= mem_read_data;
      if (w_chain[READ_LATENCY-1][1]) r_rdata1 <= mem_read_data;
    end
  end

  assign m0_rvalid = r_pipe[READ_LATENCY-1][0];
  assign m1_rvalid = r_pipe[READ_LATENCY-1][1];
  assign m0_rdata  = r_rdata0;
  assign m1_rdata  = r_rdata1;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a mode-0 instance (latency 2, starve 4, burst 4)
// and a round-robin instance (latency 1, burst 4) driven by the same master inputs.
module tb_mem_port_arbiter;
  logic        clk;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;

  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_we;
  logic [31:0] m0_rdata, m1_rdata, mem_data_addr, mem_write_data, mem_rd;
  logic [1:0]  owner, dbg_state;

  logic        b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid, b_mem_we;
  logic [31:0] b_m0_rdata, b_m1_rdata, b_mem_data_addr, b_mem_write_data, b_mem_rd;
  logic [1:0]  b_owner, b_dbg_state;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  mem_port_arbiter #(.READ_LATENCY(2), .PRIORITY_MODE(0), .STARVE_LIMIT(4), .MAX_BURST(4)) u_dut0 (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_lock(m1_lock),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .owner(owner), .mem_we(mem_we), .mem_data_addr(mem_data_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_rd), .dbg_state(dbg_state)
  );

  mem_port_arbiter #(.READ_LATENCY(1), .PRIORITY_MODE(1), .STARVE_LIMIT(8), .MAX_BURST(4)) u_dut1 (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_lock(m1_lock),
    .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata),
    .owner(b_owner), .mem_we(b_mem_we), .mem_data_addr(b_mem_data_addr),
    .mem_write_data(b_mem_write_data), .mem_read_data(b_mem_rd), .dbg_state(b_dbg_state)
  );

  // Memory contents as a pure function of the address.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a == 32'h40) ? 32'hDEADBEEF : (a ^ 32'hA5A5_0000);
  endfunction

  // Instance 0 sees a one-register memory, instance 1 a combinational one.
  always @(posedge clk) mem_rd <= mem_f(mem_data_addr);
  assign b_mem_rd = mem_f(b_mem_data_addr);

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_lock = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    cyc();
    rst = 0;
    cyc();
    cyc();
    rst = 1;
  endtask

  task automatic test_reset();
    m0_req = 1; m0_we = 1; m0_addr = 32'h10; m0_wdata = 32'h55;
    m1_req = 1; m1_we = 0; m1_addr = 32'h20;
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(); #3;
      checks++;
      if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid} !== 4'b0000) begin
        errors++; $display("FAIL reset_gnt_rvalid c%0d: got %b expected 0000", i, {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid});
      end
      checks++;
      if ({owner, mem_we} !== 3'b000 || mem_data_addr !== 32'h0 || mem_write_data !== 32'h0) begin
        errors++; $display("FAIL reset_mem c%0d: got owner=%b we=%b addr=%h wd=%h expected zeros", i, owner, mem_we, mem_data_addr, mem_write_data);
      end
      checks++;
      if (b_owner !== 2'b00 || b_m0_rvalid !== 1'b0 || b_m1_rvalid !== 1'b0) begin
        errors++; $display("FAIL reset_rr c%0d: got owner=%b rv=%b%b expected 00 00", i, b_owner, b_m1_rvalid, b_m0_rvalid);
      end
    end
    cyc(); rst = 1; #3;
    checks++;
    if (owner !== 2'b01) begin errors++; $display("FAIL reset_release_owner: got %b expected 01", owner); end
    checks++;
    if (mem_we !== 1'b1 || mem_data_addr !== 32'h10 || mem_write_data !== 32'h55) begin
      errors++; $display("FAIL reset_release_mem: got we=%b addr=%h wd=%h expected 1 10 55", mem_we, mem_data_addr, mem_write_data);
    end
    checks++;
    if (b_owner !== 2'b01) begin errors++; $display("FAIL reset_release_rr: got %b expected 01", b_owner); end
  endtask

  task automatic test_latency();
    do_reset();
    m0_req = 1; m0_we = 0; m0_addr = 32'h40; #3;
    checks++;
    if (m0_gnt !== 1'b1 || mem_data_addr !== 32'h40 || mem_we !== 1'b0) begin
      errors++; $display("FAIL lat_issue: got gnt=%b addr=%h we=%b expected 1 40 0", m0_gnt, mem_data_addr, mem_we);
    end
    cyc(); m0_req = 0; #3;
    checks++;
    if (m0_rvalid !== 1'b0) begin errors++; $display("FAIL lat_early_rvalid: got %b expected 0", m0_rvalid); end
    checks++;
    if (b_m0_rvalid !== 1'b1 || b_m0_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL lat1_return: got rv=%b data=%h expected 1 deadbeef", b_m0_rvalid, b_m0_rdata);
    end
    cyc(); #3;
    checks++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hDEADBEEF || m1_rvalid !== 1'b0) begin
      errors++; $display("FAIL lat2_return: got rv0=%b data=%h rv1=%b expected 1 deadbeef 0", m0_rvalid, m0_rdata, m1_rvalid);
    end
    checks++;
    if (b_m0_rvalid !== 1'b0) begin errors++; $display("FAIL lat1_pulse: got %b expected 0", b_m0_rvalid); end
    cyc(); #3;
    checks++;
    if (m0_rvalid !== 1'b0 || m0_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL lat_hold: got rv=%b data=%h expected 0 deadbeef", m0_rvalid, m0_rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  iss    [5] = '{2'b01, 2'b10, 2'b01, 2'b00, 2'b00};
    logic [31:0] addr   [5] = '{32'h100, 32'h200, 32'h300, 32'h0, 32'h0};
    logic [1:0]  exp_rv [5] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b01};
    logic [31:0] exp_d;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      m0_req = iss[i][0]; m0_we = 0; m0_addr = addr[i];
      m1_req = iss[i][1]; m1_we = 0; m1_addr = addr[i];
      if (iss[i] != 2'b00) exp_q.push_back(mem_f(addr[i]));
      #3;
      checks++;
      if (owner !== iss[i]) begin errors++; $display("FAIL b2b_owner c%0d: got %b expected %b", i, owner, iss[i]); end
      checks++;
      if ({m1_rvalid, m0_rvalid} !== exp_rv[i]) begin
        errors++; $display("FAIL b2b_rvalid c%0d: got %b expected %b", i, {m1_rvalid, m0_rvalid}, exp_rv[i]);
      end
      if (exp_rv[i] != 2'b00 && exp_q.size() > 0) begin
        exp_d = exp_q.pop_front();
        checks++;
        if ((exp_rv[i][0] ? m0_rdata : m1_rdata) !== exp_d) begin
          errors++; $display("FAIL b2b_rdata c%0d: got %h expected %h", i, exp_rv[i][0] ? m0_rdata : m1_rdata, exp_d);
        end
      end
      if (i == 3) begin
        checks++;
        if (m0_rdata !== mem_f(32'h100)) begin errors++; $display("FAIL b2b_m0_hold: got %h expected %h", m0_rdata, mem_f(32'h100)); end
      end
      cyc();
    end
    idle_inputs();
  endtask

  task automatic test_starvation();
    logic [1:0] exp_own [10] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    do_reset();
    m0_req = 1; m0_we = 1; m0_addr = 32'hA0; m0_wdata = 32'h1111_0000;
    m1_req = 1; m1_we = 1; m1_addr = 32'hB0; m1_wdata = 32'h2222_0000;
    for (int i = 0; i < 10; i++) begin
      #3;
      checks++;
      if (owner !== exp_own[i]) begin errors++; $display("FAIL starve_owner c%0d: got %b expected %b", i, owner, exp_own[i]); end
      checks++;
      if (mem_we !== 1'b1 || mem_write_data !== (exp_own[i][1] ? 32'h2222_0000 : 32'h1111_0000)) begin
        errors++; $display("FAIL starve_wdata c%0d: got we=%b wd=%h", i, mem_we, mem_write_data);
      end
      cyc();
    end
    idle_inputs();
  endtask

  task automatic test_round_robin();
    do_reset();
    m0_req = 1; m0_we = 1; m1_req = 1; m1_we = 1;
    for (int i = 0; i < 6; i++) begin
      #3;
      checks++;
      if (b_owner !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        errors++; $display("FAIL rr_owner c%0d: got %b expected %b", i, b_owner, (i % 2 == 0) ? 2'b01 : 2'b10);
      end
      cyc();
    end
    idle_inputs();
  endtask

  task automatic test_locked_burst();
    logic [2:0] stim   [10] = '{3'b011, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b101, 3'b110, 3'b110};
    logic [1:0] exp_rr [10] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b00, 2'b10, 2'b01};
    logic [1:0] exp_fp [10] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
    logic [1:0] exp_st [10] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0};
    do_reset();
    m0_we = 1; m1_we = 1;
    for (int i = 0; i < 10; i++) begin
      m0_req = stim[i][2]; m1_req = stim[i][1]; m1_lock = stim[i][0];
      #3;
      checks++;
      if (b_owner !== exp_rr[i]) begin errors++; $display("FAIL burst_rr_owner c%0d: got %b expected %b", i, b_owner, exp_rr[i]); end
      checks++;
      if (b_dbg_state !== exp_st[i]) begin errors++; $display("FAIL burst_rr_state c%0d: got %0d expected %0d", i, b_dbg_state, exp_st[i]); end
      checks++;
      if (owner !== exp_fp[i]) begin errors++; $display("FAIL burst_fp_owner c%0d: got %b expected %b", i, owner, exp_fp[i]); end
      cyc();
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    m1_req = 1; m1_we = 0; m1_addr = 32'h80; #3;
    checks++;
    if (m1_gnt !== 1'b1) begin errors++; $display("FAIL midrst_issue: got %b expected 1", m1_gnt); end
    cyc(); m1_req = 0; #2; rst = 0; #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (m1_rvalid !== 1'b0 || m1_rdata !== 32'h0) begin
        errors++; $display("FAIL midrst_rvalid s%0d: got rv=%b data=%h expected 0 0", i, m1_rvalid, m1_rdata);
      end
      cyc();
      if (i == 0) rst = 1;
      #3;
    end
  endtask

  task automatic test_write_gating();
    do_reset();
    m0_we = 1; m1_we = 1; m0_addr = 32'hC4; m1_addr = 32'hC0; m1_wdata = 32'h77; #3;
    checks++;
    if (mem_we !== 1'b0 || mem_data_addr !== 32'h0 || mem_write_data !== 32'h0) begin
      errors++; $display("FAIL wr_no_grant: got we=%b addr=%h wd=%h expected 0 0 0", mem_we, mem_data_addr, mem_write_data);
    end
    cyc(); m1_req = 1; #3;
    checks++;
    if (m1_gnt !== 1'b1 || mem_we !== 1'b1 || mem_data_addr !== 32'hC0 || mem_write_data !== 32'h77) begin
      errors++; $display("FAIL wr_grant: got gnt=%b we=%b addr=%h wd=%h expected 1 1 c0 77", m1_gnt, mem_we, mem_data_addr, mem_write_data);
    end
    cyc();
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    #2 rst = 0;
    test_reset();
    test_latency();
    test_back_to_back();
    test_starvation();
    test_round_robin();
    test_locked_burst();
    test_reset_mid_read();
    test_write_gating();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
